// File: rtl/uint32_bus_pkg.sv
// Shared constants and types for the MCS51 bus latch that feeds the hex display driver.
package uint32_bus_pkg;

  localparam logic [2:0] ADDR_B0   = 3'd0;
  localparam logic [2:0] ADDR_B1   = 3'd1;
  localparam logic [2:0] ADDR_B2   = 3'd2;
  localparam logic [2:0] ADDR_B3   = 3'd3;
  localparam logic [2:0] ADDR_CTRL = 3'd4;

  localparam int CTRL_OE     = 0;
  localparam int CTRL_COMMIT = 1;

  localparam int NUM_BYTES = 4;

  // Element 0 is bits [7:0] of the display word.
  typedef logic [NUM_BYTES-1:0][7:0] shadow_t;

endpackage

// File: rtl/bus_sync_edge.sv
// Two-flop synchronizer for an asynchronous strobe, plus a third flop for rising-edge detect.
module bus_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic async_sig,
  output logic synced,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
      prev_reg <= RESET_VAL;
    end else begin
      meta_reg <= async_sig;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign synced = sync_reg;
  assign rise   = sync_reg & ~prev_reg;

endmodule

// File: rtl/uint32_bus_latch.sv
// Captures MCS51 byte writes into a shadow word and commits it atomically to the display.
// Optional inactivity blanking is compiled in with UINT32_BUS_LATCH_TIMEOUT_EN.
module uint32_bus_latch
  import uint32_bus_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1024,
  parameter logic [23:0] TIMEOUT  = 24'd12000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        bus_wr_n,
  input  logic        bus_cs,
  input  logic [2:0]  bus_addr,
  input  logic [7:0]  bus_data,
  output logic [31:0] data,
  output logic        oe,
  output logic        scan_clk,
  output logic        busy
);

  localparam logic [15:0] SCAN_TC = 16'(SCAN_DIV - 1);

  logic        wr_synced;
  logic        wr_rise;
  logic        cs_synced;
  logic        cs_rise_unused;
  logic        cs_prev_reg;
  logic [2:0]  addr_hold_reg;
  logic [7:0]  byte_hold_reg;
  logic        wr_event;
  logic [3:0]  byte_sel;
  logic        ctrl_sel;
  logic        commit;
  shadow_t     shadow_word;
  logic [31:0] commit_word;
  logic [31:0] data_reg;
  logic        ctrl_oe_reg;
  logic        oe_reg;
  logic        oe_next;
  logic        busy_reg;
  logic [15:0] presc_reg;
  logic        scan_clk_reg;

  bus_sync_edge #(.RESET_VAL(1'b1)) u_wr_sync (
    .CLK       (CLK),
    .RST       (RST),
    .async_sig (bus_wr_n),
    .synced    (wr_synced),
    .rise      (wr_rise)
  );

  bus_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .CLK       (CLK),
    .RST       (RST),
    .async_sig (bus_cs),
    .synced    (cs_synced),
    .rise      (cs_rise_unused)
  );

  always_ff @(posedge CLK) begin
    if (RST) cs_prev_reg <= 1'b1;
    else     cs_prev_reg <= cs_synced;
  end

  // Address and data are stable for the whole strobe, so they are sampled directly.
  always_ff @(posedge CLK) begin
    if (!wr_synced && cs_synced) begin
      addr_hold_reg <= bus_addr;
      byte_hold_reg <= bus_data;
    end
  end

  assign wr_event = wr_rise & cs_prev_reg;

  always_comb begin
    byte_sel = '0;
    ctrl_sel = 1'b0;
    if (wr_event) begin
      case (addr_hold_reg)
        ADDR_B0:   byte_sel[0] = 1'b1;
        ADDR_B1:   byte_sel[1] = 1'b1;
        ADDR_B2:   byte_sel[2] = 1'b1;
        ADDR_B3:   byte_sel[3] = 1'b1;
        ADDR_CTRL: ctrl_sel    = 1'b1;
        default:   ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_shadow
      logic [7:0] byte_reg;
      always_ff @(posedge CLK) begin
        if (RST)               byte_reg <= '0;
        else if (byte_sel[gi]) byte_reg <= byte_hold_reg;
      end
      assign shadow_word[gi] = byte_reg;
    end
  endgenerate

  // A byte-3 write commits the incoming byte alongside the already-held lower bytes.
  assign commit      = byte_sel[3] | (ctrl_sel & byte_hold_reg[CTRL_COMMIT]);
  assign commit_word = byte_sel[3] ? {byte_hold_reg, shadow_word[2:0]} : shadow_word;

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_reg    <= '0;
      busy_reg    <= 1'b0;
      ctrl_oe_reg <= 1'b0;
      oe_reg      <= 1'b0;
    end else begin
      busy_reg <= commit;
      if (commit)   data_reg    <= commit_word;
      if (ctrl_sel) ctrl_oe_reg <= byte_hold_reg[CTRL_OE];
      oe_reg <= oe_next;
    end
  end

`ifdef UINT32_BUS_LATCH_TIMEOUT_EN
  logic [23:0] idle_cnt_reg;
  logic        timed_out;

  assign timed_out = (idle_cnt_reg == TIMEOUT);

  // Saturates at TIMEOUT so the display stays blank until the next commit.
  always_ff @(posedge CLK) begin
    if (RST)             idle_cnt_reg <= '0;
    else if (commit)     idle_cnt_reg <= '0;
    else if (!timed_out) idle_cnt_reg <= idle_cnt_reg + 24'd1;
  end

  assign oe_next = ctrl_oe_reg & ~timed_out;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign oe_next = ctrl_oe_reg;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_reg    <= '0;
      scan_clk_reg <= 1'b0;
    end else if (presc_reg == SCAN_TC) begin
      presc_reg    <= '0;
      scan_clk_reg <= ~scan_clk_reg;
    end else begin
      presc_reg <= presc_reg + 16'd1;
    end
  end

  assign data     = data_reg;
  assign oe       = oe_reg;
  assign busy     = busy_reg;
  assign scan_clk = scan_clk_reg;

endmodule

// File: tb/tb_uint32_bus_latch.sv
// Directed plus randomized bench for uint32_bus_latch against a byte-level reference model.
// Honours UINT32_BUS_LATCH_TIMEOUT_EN to exercise display blanking.
module tb_uint32_bus_latch;

  localparam int SDIV = 4;
`ifdef UINT32_BUS_LATCH_TIMEOUT_EN
  localparam int TMO = 100;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        bus_wr_n = 1'b1;
  logic        bus_cs = 1'b0;
  logic [2:0]  bus_addr = '0;
  logic [7:0]  bus_data = '0;
  logic [31:0] data;
  logic        oe;
  logic        scan_clk;
  logic        busy;

  uint32_bus_latch #(
    .SCAN_DIV (SDIV),
    .TIMEOUT  (24'd100)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus_wr_n (bus_wr_n),
    .bus_cs   (bus_cs),
    .bus_addr (bus_addr),
    .bus_data (bus_data),
    .data     (data),
    .oe       (oe),
    .scan_clk (scan_clk),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0]  m_shadow [4];
  logic [31:0] m_word;
  logic        m_ctrl0;
  int          m_reset_edge;
  int          m_last_commit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_scan();
    return 1'(((edge_cnt - m_reset_edge) / SDIV) % 2);
  endfunction

  function automatic logic exp_oe();
`ifdef UINT32_BUS_LATCH_TIMEOUT_EN
    return m_ctrl0 && ((edge_cnt - m_last_commit) <= TMO);
`else
    return m_ctrl0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_shadow[i] = 8'h00;
    m_word        = 32'h0;
    m_ctrl0       = 1'b0;
    m_reset_edge  = edge_cnt;
    m_last_commit = edge_cnt;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  // One complete bus write; checks latency, busy pulse, oe and scan_clk on every edge.
  task automatic bus_write(input logic [2:0] a, input logic [7:0] d, input int low_cycles);
    logic [31:0] old_word;
    logic        commit;
    old_word = m_word;
    commit   = 1'b0;
    @(negedge CLK);
    bus_addr = a;
    bus_data = d;
    bus_cs   = 1'b1;
    bus_wr_n = 1'b0;
    repeat (low_cycles) @(negedge CLK);
    bus_wr_n = 1'b1;
    case (a)
      3'd0, 3'd1, 3'd2: m_shadow[a] = d;
      3'd3: begin
        m_shadow[3] = d;
        commit = 1'b1;
      end
      3'd4: begin
        m_ctrl0 = d[0];
        commit  = d[1];
      end
      default: ;
    endcase
    if (commit) m_word = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLK);
      #1;
      check("scan_clk", scan_clk, exp_scan());
      if (k < 3) begin
        check("data_early", data, old_word);
        check("busy_early", busy, 0);
      end else if (k == 3) begin
        check("data_commit", data, m_word);
        check("busy_pulse", busy, commit);
        if (commit) m_last_commit = edge_cnt;
      end else begin
        check("busy_clear", busy, 0);
        check("oe", oe, exp_oe());
      end
    end
    bus_cs = 1'b0;
    $display("wr addr=%0d data=0x%02h low=%0d word=0x%08h oe=%0b", a, d, low_cycles, data, oe);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic busy_seen;
    logic [2:0] ra;
    logic [7:0] rd;

    // Reset state
    do_reset();
    check("rst_data", data, 32'h0);
    check("rst_oe", oe, 0);
    check("rst_scan", scan_clk, 0);
    check("rst_busy", busy, 0);

    // Byte writes then commit through byte 3
    bus_write(3'd0, 8'h78, 3);
    bus_write(3'd1, 8'h56, 3);
    bus_write(3'd2, 8'h34, 3);
    check("no_commit_yet", data, 32'h0);
    bus_write(3'd3, 8'h12, 3);
    check("commit_word", data, 32'h12345678);

    // Control register
    bus_write(3'd4, 8'h01, 2);
    check("oe_on", oe, 1);
    bus_write(3'd4, 8'h00, 2);
    check("oe_off", oe, 0);
    bus_write(3'd0, 8'hAA, 2);
    check("shadow_only", data, 32'h12345678);
    bus_write(3'd4, 8'h02, 2);
    check("force_commit", data, 32'h123456AA);
    check("force_oe", oe, 0);

    // Ignored address
    bus_write(3'd6, 8'hFF, 3);
    check("ignored_addr", data, 32'h123456AA);

    // cs dropped two clocks before wr_n rises
    @(negedge CLK);
    bus_addr = 3'd3; bus_data = 8'hEE; bus_cs = 1'b1; bus_wr_n = 1'b0;
    repeat (3) @(negedge CLK);
    bus_cs = 1'b0;
    repeat (2) @(negedge CLK);
    bus_wr_n = 1'b1;
    busy_seen = 1'b0;
    repeat (5) begin
      @(posedge CLK); #1;
      busy_seen |= busy;
      check("scan_clk", scan_clk, exp_scan());
    end
    check("cs_drop_data", data, m_word);
    check("cs_drop_busy", busy_seen, 0);
    $display("cs-drop strobe word=0x%08h", data);

    // Reset during the low phase: wr_n rising during RST, then in the first cycle after
    for (int v = 0; v < 2; v++) begin
      @(negedge CLK);
      bus_addr = 3'd3; bus_data = 8'h99; bus_cs = 1'b1; bus_wr_n = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      if (v == 0) begin
        @(negedge CLK);
        bus_wr_n = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
      end else begin
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        bus_wr_n = 1'b1;
      end
      model_reset();
      busy_seen = 1'b0;
      repeat (5) begin
        @(posedge CLK); #1;
        busy_seen |= busy;
        check("scan_clk", scan_clk, exp_scan());
      end
      check("rst_strobe_data", data, 32'h0);
      check("rst_strobe_busy", busy_seen, 0);
      bus_cs = 1'b0;
      $display("reset-mid-strobe variant=%0d word=0x%08h", v, data);
    end

    // Randomized writes against the model
    for (int n = 0; n < 40; n++) begin
      ra = 3'($urandom_range(0, 7));
      rd = 8'($urandom);
      bus_write(ra, rd, int'($urandom_range(2, 5)));
    end

`ifdef UINT32_BUS_LATCH_TIMEOUT_EN
    // Enable with commit, let the display blank, then revive it with a commit
    bus_write(3'd4, 8'h03, 2);
    check("tmo_oe_on", oe, 1);
    while (edge_cnt < m_last_commit + TMO + 3) begin
      @(posedge CLK); #1;
      check("tmo_oe", oe, exp_oe());
    end
    check("tmo_blanked", oe, 0);
    bus_write(3'd3, 8'h5A, 2);
    check("tmo_revived", oe, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
